// File: rtl/compliance_sim_pkg.sv
// Shared register map, FSM state encoding and checksum helpers for the
// compliance simulation controller.
package compliance_sim_pkg;

    localparam int unsigned CHECKSUM_W = 32;

    localparam logic [3:0] OFF_CHAR   = 4'h0;
    localparam logic [3:0] OFF_CYCLES = 4'h4;
    localparam logic [3:0] OFF_HALT   = 4'h8;
    localparam logic [3:0] OFF_SIG    = 4'hC;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } sim_state_e;

    function automatic logic [CHECKSUM_W-1:0] sig_accumulate(
        input logic [CHECKSUM_W-1:0] sum,
        input logic [31:0]           data
    );
        return sum + data;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'h0001;
        end
    endfunction

endpackage

// File: rtl/compliance_watchdog.sv
// Enabled free-running cycle counter; expire_o pulses combinationally while
// enabled on the cycle the count sits at Cycles-1.
module compliance_watchdog #(
    parameter int unsigned Cycles = 100000,
    parameter int unsigned Width  = $clog2(Cycles + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o,
    output logic             expire_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    // Next count: advance only while enabled.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + Width'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= {Width{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign expire_o = en_i && (count_q == Width'(Cycles - 1));

endmodule

// File: rtl/compliance_sim_ctrl.sv
// Simulation-control responder on the Ibex data bus: console output, signature
// checksum, end-of-test halt and watchdog. Optional COMPLIANCE_SIM_CTRL_PRINT_EN
// adds console printing and self-termination in simulation.
module compliance_sim_ctrl
    import compliance_sim_pkg::*;
#(
    parameter int unsigned          AddrWidth     = 32,
    parameter logic [AddrWidth-1:0] BaseAddr      = AddrWidth'(32'h0002_0000),
    parameter int unsigned          TimeoutCycles = 100000,
    parameter int unsigned          DrainCycles   = 4
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_sys_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [31:0]          wdata_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    output logic                 char_valid_o,
    output logic [7:0]           char_o,
    output logic                 halt_o,
    output logic                 pass_o,
    output logic                 timeout_o,
    output logic [15:0]          sig_count_o
);

    localparam int unsigned WdWidth    = $clog2(TimeoutCycles + 1);
    localparam int unsigned DrainWidth = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;

    sim_state_e            state_q, state_d;
    logic [DrainWidth-1:0] drain_q, drain_d;
    logic [31:0]           result_q, result_d;
    logic [CHECKSUM_W-1:0] checksum_q;
    logic [15:0]           sig_count_q;
    logic                  rvalid_q, err_q, char_valid_q;
    logic [31:0]           rdata_q;
    logic [7:0]            char_q;
    logic                  halt_q, pass_q, timeout_q;

    logic [AddrWidth-1:0]  offset_s;
    logic                  hit_s, wr_char_s, wr_halt_s, wr_sig_s;
    logic [31:0]           rdata_s;
    logic [WdWidth-1:0]    wd_count_s;
    logic                  wd_expire_s;
    logic                  unused_be_s;

    assign unused_be_s = ^be_i[3:1];

    compliance_watchdog #(
        .Cycles (TimeoutCycles),
        .Width  (WdWidth)
    ) u_watchdog (
        .clk_i    (clk_sys_i),
        .rst_i    (rst_sys_i),
        .en_i     (state_q == RUN),
        .count_o  (wd_count_s),
        .expire_o (wd_expire_s)
    );

    // Address decode; the subtraction wraps, so addresses below BaseAddr miss too.
    always_comb begin
        offset_s  = addr_i - BaseAddr;
        hit_s     = (offset_s < AddrWidth'(5'd16)) && (addr_i[1:0] == 2'b00);
        wr_char_s = 1'b0;
        wr_halt_s = 1'b0;
        wr_sig_s  = 1'b0;
        rdata_s   = 32'h0000_0000;
        if (req_i && hit_s) begin
            case (offset_s[3:0])
                OFF_CHAR:   wr_char_s = we_i && be_i[0];
                OFF_CYCLES: rdata_s   = we_i ? 32'h0000_0000 : 32'(wd_count_s);
                OFF_HALT:   wr_halt_s = we_i && (state_q == RUN);
                OFF_SIG: begin
                    if (we_i) begin
                        wr_sig_s = (state_q == RUN) || (state_q == DRAIN);
                    end else begin
                        rdata_s = checksum_q;
                    end
                end
                default:    rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // FSM next state; a HALT write beats a same-cycle watchdog expiry.
    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        result_d = result_q;
        case (state_q)
            RUN: begin
                if (wr_halt_s) begin
                    state_d  = DRAIN;
                    drain_d  = {DrainWidth{1'b0}};
                    result_d = wdata_i;
                end else if (wd_expire_s) begin
                    state_d = TIMEOUT;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (drain_q == DrainWidth'(DrainCycles - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DrainWidth'(1'b1);
                end
            end
            DONE:    state_d = DONE;
            TIMEOUT: state_d = TIMEOUT;
            default: state_d = RUN;
        endcase
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state_q   <= RUN;
            drain_q   <= {DrainWidth{1'b0}};
            result_q  <= 32'h0000_0000;
            halt_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            result_q  <= result_d;
            halt_q    <= (state_d == DONE) || (state_d == TIMEOUT);
            pass_q    <= (state_d == DONE) && (result_d == 32'h0000_0000);
            timeout_q <= (state_d == TIMEOUT);
        end
    end

    // Bus response, console character and signature bookkeeping.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            rvalid_q     <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            char_valid_q <= 1'b0;
            char_q       <= 8'h00;
            checksum_q   <= {CHECKSUM_W{1'b0}};
            sig_count_q  <= 16'h0000;
        end else begin
            rvalid_q     <= req_i;
            err_q        <= req_i && !hit_s;
            rdata_q      <= rdata_s;
            char_valid_q <= wr_char_s;
            if (wr_char_s) begin
                char_q <= wdata_i[7:0];
            end
            if (wr_sig_s) begin
                checksum_q  <= sig_accumulate(checksum_q, wdata_i);
                sig_count_q <= sat_inc16(sig_count_q);
            end
        end
    end

`ifdef COMPLIANCE_SIM_CTRL_PRINT_EN
    // Console echo and end-of-test reporting for standalone simulation.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_i) begin
            if (char_valid_q) begin
                $write("%c", char_q);
            end
            if ((state_d == DONE) && (state_q != DONE)) begin
                if (result_d == 32'h0000_0000) begin
                    $display("PASS checksum=%08h", checksum_q);
                end else begin
                    $display("FAIL code=%0d checksum=%08h", result_d, checksum_q);
                end
                $finish;
            end
            if ((state_d == TIMEOUT) && (state_q != TIMEOUT)) begin
                $display("TIMEOUT");
                $finish;
            end
        end
    end
`else
    // Quiet build: the surrounding bench watches halt_o and decides when to stop.
`endif

    assign gnt_o        = req_i;
    assign rvalid_o     = rvalid_q;
    assign rdata_o      = rdata_q;
    assign err_o        = err_q;
    assign char_valid_o = char_valid_q;
    assign char_o       = char_q;
    assign halt_o       = halt_q;
    assign pass_o       = pass_q;
    assign timeout_o    = timeout_q;
    assign sig_count_o  = sig_count_q;

endmodule

// File: tb/tb_compliance_sim_ctrl.sv
// Scoreboard bench for compliance_sim_ctrl: stimulus queues expected bus
// responses and characters, a negedge monitor pops and compares them.
module tb_compliance_sim_ctrl;

    localparam logic [31:0] BASE = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'h0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        gnt_o, rvalid_o, err_o, char_valid_o, halt_o, pass_o, timeout_o;
    logic [31:0] rdata_o;
    logic [7:0]  char_o;
    logic [15:0] sig_count_o;

    always #5 clk = ~clk;

    compliance_sim_ctrl #(
        .AddrWidth     (32),
        .BaseAddr      (BASE),
        .TimeoutCycles (50),
        .DrainCycles   (4)
    ) dut (
        .clk_sys_i    (clk),
        .rst_sys_i    (rst),
        .req_i        (req_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .char_valid_o (char_valid_o),
        .char_o       (char_o),
        .halt_o       (halt_o),
        .pass_o       (pass_o),
        .timeout_o    (timeout_o),
        .sig_count_o  (sig_count_o)
    );

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
        string       name;
    } resp_t;

    resp_t      rq[$];
    logic [7:0] cq[$];
    int         checks = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    // One bus access: queue the expected response, present for one grant cycle.
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic e, input logic c,
                       input logic [31:0] x, input string n);
        resp_t r;
        r.err = e; r.chk = c; r.data = x; r.name = n;
        rq.push_back(r);
        req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d; be_i = b;
        #1;
        check({n, "_gnt"}, {31'h0, gnt_o}, 32'h1);
        @(posedge clk);
        #1;
        req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic e, input string n);
        bus(1'b1, a, d, 4'hF, e, 1'b0, 32'h0, n);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] x, input logic e, input string n);
        bus(1'b0, a, 32'h0, 4'h0, e, 1'b1, x, n);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_zero(input string n);
        check({n, "_rvalid"}, {31'h0, rvalid_o}, 32'h0);
        check({n, "_rdata"}, rdata_o, 32'h0);
        check({n, "_err"}, {31'h0, err_o}, 32'h0);
        check({n, "_charv"}, {31'h0, char_valid_o}, 32'h0);
        check({n, "_char"}, {24'h0, char_o}, 32'h0);
        check({n, "_halt"}, {31'h0, halt_o}, 32'h0);
        check({n, "_pass"}, {31'h0, pass_o}, 32'h0);
        check({n, "_timeout"}, {31'h0, timeout_o}, 32'h0);
        check({n, "_sigcnt"}, {16'h0, sig_count_o}, 32'h0);
    endtask

    task automatic check_status(input string n, input logic h, input logic p, input logic t);
        check({n, "_halt"}, {31'h0, halt_o}, {31'h0, h});
        check({n, "_pass"}, {31'h0, pass_o}, {31'h0, p});
        check({n, "_timeout"}, {31'h0, timeout_o}, {31'h0, t});
    endtask

    // Monitor: every rvalid and every char pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid_o) begin
                if (rq.size() == 0) begin
                    check("unexpected_rvalid", 32'h1, 32'h0);
                end else begin
                    resp_t r;
                    r = rq.pop_front();
                    check({r.name, "_rsp_err"}, {31'h0, err_o}, {31'h0, r.err});
                    if (r.chk) begin
                        check({r.name, "_rsp_data"}, rdata_o, r.data);
                    end
                end
            end
            if (char_valid_o) begin
                if (cq.size() == 0) begin
                    check("unexpected_char", {24'h0, char_o}, 32'h0);
                end else begin
                    logic [7:0] c;
                    c = cq.pop_front();
                    check("char_value", {24'h0, char_o}, {24'h0, c});
                    check("char_with_rvalid", {31'h0, rvalid_o}, 32'h1);
                end
            end
        end
    end

    initial begin
        // Reset state, idle watchdog count.
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        check_zero("idle");
        check("idle_gnt", {31'h0, gnt_o}, 32'h0);
        rd(BASE + 32'h4, 32'd10, 1'b0, "cycles_rd");

        // Console characters, byte-enable gating, CHAR readback, CYCLES write.
        cq.push_back(8'h48);
        wr(BASE, 32'h0000_0048, 1'b0, "char_h");
        cq.push_back(8'h69);
        wr(BASE, 32'hABCD_EF69, 1'b0, "char_i");
        bus(1'b1, BASE, 32'h0000_0021, 4'b1110, 1'b0, 1'b0, 32'h0, "char_nobe");
        rd(BASE, 32'h0, 1'b0, "char_rd");
        wr(BASE + 32'h4, 32'd123, 1'b0, "cycles_wr");

        // Signature accumulation wraps mod 2^32.
        wr(BASE + 32'hC, 32'h0000_0010, 1'b0, "sig1");
        wr(BASE + 32'hC, 32'h0000_0020, 1'b0, "sig2");
        wr(BASE + 32'hC, 32'hFFFF_FFF0, 1'b0, "sig3");
        rd(BASE + 32'hC, 32'h0000_0020, 1'b0, "sig_rd");
        check("sig_count3", {16'h0, sig_count_o}, 32'd3);

        // HALT 0: SIG still accepted in DRAIN, DONE after four drain cycles.
        wr(BASE + 32'h8, 32'h0, 1'b0, "halt0");
        check_status("drain0", 1'b0, 1'b0, 1'b0);
        wr(BASE + 32'hC, 32'h0, 1'b0, "sig_drain");
        check("sig_count_drain", {16'h0, sig_count_o}, 32'd4);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_status("drain", 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
        check_status("done", 1'b1, 1'b1, 1'b0);
        wr(BASE + 32'hC, 32'h0000_0005, 1'b0, "sig_done");
        check("sig_count_done", {16'h0, sig_count_o}, 32'd4);
        rd(BASE + 32'hC, 32'h0000_0020, 1'b0, "sig_rd_done");

        // Watchdog expiry at cycle 50, then frozen and terminal.
        do_reset();
        #1;
        check_zero("rst1");
        repeat (49) @(posedge clk);
        #1;
        check_status("pre_timeout", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_status("timeout", 1'b1, 1'b0, 1'b1);
        rd(BASE + 32'h4, 32'd50, 1'b0, "cycles_frozen");
        wr(BASE + 32'h8, 32'h0, 1'b0, "halt_in_timeout");
        repeat (5) @(posedge clk);
        #1;
        check_status("timeout_hold", 1'b1, 1'b0, 1'b1);
        rd(BASE + 32'h4, 32'd50, 1'b0, "cycles_frozen2");
        do_reset();
        #1;
        check_zero("rst2");

        // HALT write on the expiry cycle: halt wins.
        repeat (49) @(posedge clk);
        #1;
        check_status("race_pre", 1'b0, 1'b0, 1'b0);
        wr(BASE + 32'h8, 32'h0, 1'b0, "halt_race");
        check_status("race_drain", 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_status("race_done", 1'b1, 1'b1, 1'b0);
        rd(BASE + 32'h4, 32'd50, 1'b0, "race_cycles");

        // Decode errors have no side effects; HALT 5 fails the test.
        do_reset();
        rd(BASE + 32'h20, 32'h0, 1'b1, "err_far");
        rd(BASE + 32'h2, 32'h0, 1'b1, "err_misal");
        rd(BASE - 32'h4, 32'h0, 1'b1, "err_below");
        wr(BASE + 32'h9, 32'h0, 1'b1, "err_halt_misal");
        wr(BASE + 32'h1C, 32'h5, 1'b1, "err_sig_alias");
        wr(BASE + 32'h10, 32'h0, 1'b1, "err_edge");
        wr(BASE + 32'h1, 32'h41, 1'b1, "err_char_misal");
        repeat (6) @(posedge clk);
        #1;
        check_status("err_nostate", 1'b0, 1'b0, 1'b0);
        check("err_sigcnt", {16'h0, sig_count_o}, 32'h0);
        rd(BASE + 32'hC, 32'h0, 1'b0, "err_sum");
        wr(BASE + 32'h8, 32'h5, 1'b0, "halt5");
        repeat (4) @(posedge clk);
        #1;
        check_status("fail_done", 1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("rsp_queue_empty", rq.size(), 32'h0);
        check("char_queue_empty", cq.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/compliance_sim_ctrl.md
Name: compliance_sim_ctrl

Overview:
- Memory-mapped simulation-control responder on the Ibex data bus (req/gnt/rvalid) of the compliance system.
- Accepts character output, signature writes and the end-of-test write from compliance software.
- Runs a watchdog, and presents halt/pass/fail/timeout status to the top-level bench, which uses it to stop simulation.

Parameters:
- AddrWidth, 32, width of addr_i.
- BaseAddr, 32'h0002_0000, base of the 16-byte register window.
- TimeoutCycles, 100000, RUN-state cycles before timeout_o asserts.
- DrainCycles, 4, cycles between halt request and DONE, so in-flight stores finish.

Ports:
- clk_sys_i  in  1  system clock
- rst_sys_i  in  1  synchronous active-high reset
- req_i  in  1  data request
- we_i  in  1  write enable
- be_i  in  4  byte enables
- addr_i  in  AddrWidth  byte address
- wdata_i  in  32  write data
- gnt_o  out  1  grant
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- err_o  out  1  response error, qualified by rvalid_o
- char_valid_o  out  1  one-cycle pulse, char_o valid
- char_o  out  8  output character
- halt_o  out  1  test finished (DONE or TIMEOUT)
- pass_o  out  1  DONE with result code 0
- timeout_o  out  1  watchdog expired
- sig_count_o  out  16  number of signature writes accepted

Behaviour:
- Reset (rst_sys_i high at posedge): every output 0. State RUN, counters 0, checksum 0, result code 0.
- Bus handshake:
  - gnt_o = req_i, combinational, in every state.
  - rvalid_o asserts exactly one cycle after each grant; rdata_o/err_o are valid only with rvalid_o, and rdata_o is 0 otherwise.
  - At most one outstanding access; back-to-back grants give back-to-back rvalids.
- Address decode: offset = addr_i - BaseAddr, word aligned. Any access outside [BaseAddr, BaseAddr+16) or with addr_i[1:0]!=0 gets err_o=1 with rvalid, and has no side effect.
- Offset 0x0 CHAR (write-only):
  - A write with be_i[0] set pulses char_valid_o next cycle, with char_o = wdata_i[7:0].
  - Read returns 0.
- Offset 0x4 CYCLES (read-only): returns the watchdog count, zero-extended to 32 bits. Writes are ignored without error.
- Offset 0x8 HALT (write-only):
  - Write in RUN: latch wdata_i as result code, enter DRAIN.
  - Write in DRAIN/DONE/TIMEOUT: ignored.
- Offset 0xC SIG:
  - Write: checksum = checksum + wdata_i (mod 2^32), sig_count_o increments and saturates at 16'hFFFF. Byte enables are ignored.
  - Read returns the checksum.
  - SIG writes are accepted in RUN and DRAIN only.
- FSM:
  - RUN -> DRAIN on HALT write.
  - RUN -> TIMEOUT when the watchdog count reaches TimeoutCycles-1.
  - DRAIN counts DrainCycles, then -> DONE.
  - DONE and TIMEOUT are terminal until reset.
  - halt_o=1 in DONE and TIMEOUT. pass_o=1 only in DONE with result code 0. timeout_o=1 only in TIMEOUT.
- Watchdog: increments every cycle in RUN only and freezes on leaving RUN.
- Simultaneous events: a HALT write in the same cycle the watchdog expires resolves to DRAIN, because the halt wins.
- Reset mid-operation: any state returns to RUN. A pending rvalid is dropped.

Optional Feature:
- Macro: COMPLIANCE_SIM_CTRL_PRINT_EN.
- Defined:
  - Each char_valid_o pulse also does $write of the character.
  - On entry to DONE, display "PASS"/"FAIL code=<n>" plus checksum, then $finish.
  - On TIMEOUT, display "TIMEOUT" and $finish.
- Undefined: no system tasks; ports and behaviour are otherwise identical, and the bench decides when to stop.

Decomposition:
- compliance_sim_pkg holds:
  - the register offsets CHAR/CYCLES/HALT/SIG;
  - the state enum sim_state_e {RUN, DRAIN, DONE, TIMEOUT};
  - the checksum width constant.
- One natural sub-module: compliance_watchdog, a parameterised cycle counter with enable and an expiry pulse, instantiated for the watchdog.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0. CYCLES read returns 10 (±1 for the read latency).
- Write 0x48 then 0x69 to BaseAddr+0x0 -> char_valid_o pulses, with char_o 0x48 then 0x69, each one cycle after its grant.
- Write 0x10, 0x20, 0xFFFFFFF0 to SIG, then read SIG -> rdata_o=0x00000020, sig_count_o=3.
- Write 0 to HALT -> DRAIN for 4 cycles, then halt_o=1 and pass_o=1. A later SIG write leaves sig_count_o unchanged.
- TimeoutCycles=50 with no HALT -> timeout_o=1 and halt_o=1 at cycle 50, pass_o=0. Then assert reset -> everything returns to 0.
- Read BaseAddr+0x20, then BaseAddr+0x2 -> err_o=1 with rvalid_o on both, no state change. HALT write of 5 -> halt_o=1, pass_o=0.
